// File: rtl/psum_row_collector.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// psum_row_collector
//
// Purpose:
//   Collects the dual-psum row leaving the bottom MAC row of the systolic array.
//   Column valids arrive skewed by one cycle per column. Each column writes into
//   its own FIFO. A complete, column-aligned row is popped to the downstream
//   consumer once every column FIFO holds at least one entry.
//
// Optional feature (compile-time macro):
//   PSUM_ROW_COLLECTOR_RELU_EN - when defined, every popped psum whose sign bit
//   is set is replaced by zero before it reaches out. Storage keeps raw values.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (pointers, out, overflow)
//   in_s     in   dual psums, column i at [psum_bw*(2i+2)-1 : psum_bw*2i],
//                 psum0 in the low half, psum1 in the high half
//   valid    in   per-column write strobe for in_s
//   rd       in   pop request; acted on only while o_valid is high
//   out      out  registered popped row, same packing as in_s
//   o_valid  out  every column FIFO holds at least one entry
//   o_full   out  at least one column FIFO is full
//   o_ready  out  no column FIFO is full
//   overflow out  sticky: a write to a full column was dropped
// -----------------------------------------------------------------------------
module psum_row_collector #(
  parameter int psum_bw = 9,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int ptr_bw  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [psum_bw*col*2-1:0] in_s,
  input  logic [col-1:0]           valid,
  input  logic                     rd,
  output logic [psum_bw*col*2-1:0] out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     overflow
);

  localparam int pair_bw = 2 * psum_bw;
  localparam logic [ptr_bw:0] ptr_one = {{ptr_bw{1'b0}}, 1'b1};

  // Read pointers always move together, so one shared pointer serves all columns.
  logic [ptr_bw:0]  rptr_reg;
  logic [col-1:0]   col_empty;
  logic [col-1:0]   col_full;
  logic [col-1:0]   drop;
  logic             pop;
  logic             overflow_reg;

  // Shapes a stored psum pair on its way to out.
  function automatic logic [pair_bw-1:0] shape_pair(input logic [pair_bw-1:0] p);
    logic [pair_bw-1:0] r;
    r = p;
`ifdef PSUM_ROW_COLLECTOR_RELU_EN
    if (p[psum_bw-1]) r[psum_bw-1:0] = '0;
    if (p[pair_bw-1]) r[pair_bw-1:psum_bw] = '0;
`endif
    return r;
  endfunction

  assign o_valid  = ~|col_empty;
  assign o_full   = |col_full;
  assign o_ready  = ~o_full;
  assign pop      = rd && o_valid;
  assign overflow = overflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_col
      logic [pair_bw-1:0] mem [depth];
      logic [ptr_bw:0]    wptr_reg;
      logic [pair_bw-1:0] out_col_reg;
      logic [pair_bw-1:0] in_pair;
      logic               wr_en;

      assign in_pair = in_s[gi*pair_bw +: pair_bw];

      assign col_empty[gi] = (wptr_reg == rptr_reg);
      assign col_full[gi]  = (wptr_reg[ptr_bw-1:0] == rptr_reg[ptr_bw-1:0]) &&
                             (wptr_reg[ptr_bw] != rptr_reg[ptr_bw]);

      // A pop at the same edge frees the slot a full column is about to reuse;
      // the read below still sees the old entry because both are registered.
      assign wr_en    = valid[gi] && (!col_full[gi] || pop);
      assign drop[gi] = valid[gi] && col_full[gi] && !pop;

      always_ff @(posedge clk) begin
        if (reset) begin
          wptr_reg <= '0;
        end else if (wr_en) begin
          wptr_reg <= wptr_reg + ptr_one;
        end
      end

      always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
          mem[wptr_reg[ptr_bw-1:0]] <= in_pair;
        end
      end

      // Registered read: out holds until the next accepted pop.
      always_ff @(posedge clk) begin
        if (reset) begin
          out_col_reg <= '0;
        end else if (pop) begin
          out_col_reg <= shape_pair(mem[rptr_reg[ptr_bw-1:0]]);
        end
      end

      assign out[gi*pair_bw +: pair_bw] = out_col_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_reg <= '0;
    end else if (pop) begin
      rptr_reg <= rptr_reg + ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (|drop) begin
      overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_row_collector.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_psum_row_collector
//
// Self-checking bench for psum_row_collector. The driver keeps per-column data
// queues as the reference model and pushes every expected popped row into a
// scoreboard queue; an independent monitor pops and compares out whenever the
// DUT accepts a pop. Flags are compared against the model after every cycle.
// -----------------------------------------------------------------------------
module tb_psum_row_collector;

  localparam int PW   = 9;
  localparam int COLS = 8;
  localparam int DEP  = 16;
  localparam int PB   = 4;
  localparam int RW   = PW * COLS * 2;

  logic            clk;
  logic            reset;
  logic [RW-1:0]   in_s;
  logic [COLS-1:0] valid;
  logic            rd;
  logic [RW-1:0]   out;
  logic            o_valid;
  logic            o_full;
  logic            o_ready;
  logic            overflow;

  psum_row_collector #(
    .psum_bw(PW), .col(COLS), .depth(DEP), .ptr_bw(PB)
  ) dut (
    .clk(clk), .reset(reset), .in_s(in_s), .valid(valid), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [2*PW-1:0] mq [COLS][$];
  logic [RW-1:0]   exp_q [$];
  logic            m_ovf;
  int              m_pops;
  logic            mon_en;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [RW-1:0] relu_row(input logic [RW-1:0] r);
    logic [RW-1:0] x;
    x = r;
`ifdef PSUM_ROW_COLLECTOR_RELU_EN
    for (int h = 0; h < 2*COLS; h++) begin
      if (x[h*PW + PW-1]) x[h*PW +: PW] = '0;
    end
`endif
    return x;
  endfunction

  function automatic logic [RW-1:0] make_row(input int p0, input int p1);
    logic [RW-1:0] r;
    for (int i = 0; i < COLS; i++) r[i*2*PW +: 2*PW] = {9'(p1), 9'(p0)};
    return r;
  endfunction

  // Flags straight from the queue occupancies.
  task automatic check_flags();
    logic ev, ef;
    ev = 1'b1;
    ef = 1'b0;
    for (int i = 0; i < COLS; i++) begin
      if (mq[i].size() == 0) ev = 1'b0;
      if (mq[i].size() == DEP) ef = 1'b1;
    end
    chk("o_valid", RW'(o_valid), RW'(ev));
    chk("o_full", RW'(o_full), RW'(ef));
    chk("o_ready", RW'(o_ready), RW'(!ef));
    chk("overflow", RW'(overflow), RW'(m_ovf));
  endtask

  // One clock: apply inputs, advance the model, wait past the edge, check flags.
  task automatic cycle(input logic [COLS-1:0] v, input logic [RW-1:0] d,
                       input logic r, input logic rs);
    logic do_pop;
    logic [RW-1:0] row;
    in_s  = d;
    valid = v;
    rd    = r;
    reset = rs;
    if (rs) begin
      for (int i = 0; i < COLS; i++) mq[i].delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      do_pop = r;
      for (int i = 0; i < COLS; i++) if (mq[i].size() == 0) do_pop = 1'b0;
      if (do_pop) begin
        for (int i = 0; i < COLS; i++) row[i*2*PW +: 2*PW] = mq[i].pop_front();
        exp_q.push_back(relu_row(row));
        m_pops++;
      end
      for (int i = 0; i < COLS; i++) begin
        if (v[i]) begin
          if (mq[i].size() < DEP) mq[i].push_back(d[i*2*PW +: 2*PW]);
          else m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check_flags();
  endtask

  // Monitor: on each accepted pop take the next scoreboard row; out must hold
  // that row (or zero after reset) every cycle.
  initial begin : monitor
    logic rst_s, hs;
    logic [RW-1:0] last_exp;
    last_exp = '0;
    forever begin
      @(posedge clk);
      rst_s = reset;
      hs    = rd && o_valid;
      @(negedge clk);
      if (rst_s) begin
        last_exp = '0;
      end else if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual=pop required=no_pop");
        end else begin
          last_exp = exp_q.pop_front();
        end
      end
      if (mon_en) chk("out_row", out, last_exp);
    end
  end

  initial begin : driver
    logic [RW-1:0] d;
    logic [COLS-1:0] v;
    int wr_cnt [COLS];
    int budget;

    mon_en = 1'b1;
    m_ovf  = 1'b0;
    m_pops = 0;
    in_s = '0; valid = '0; rd = 1'b0; reset = 1'b1;

    // Reset state
    cycle('0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);
    chk("reset_out", out, '0);

    // Skewed fill: column i writes in cycle i
    for (int i = 0; i < COLS; i++) begin
      d = '0;
      d[i*2*PW +: 2*PW] = {9'(i+16), 9'(i)};
      cycle(COLS'(1) << i, d, 1'b0, 1'b0);
    end
    cycle('0, '0, 1'b1, 1'b0);
    d = out;
    chk("skew_col3", RW'(d[3*2*PW +: 2*PW]), RW'({9'd19, 9'd3}));
    chk("skew_drained_valid", RW'(o_valid), RW'(0));

    // Column 0 to full, then an overflowing 17th write
    cycle('0, '0, 1'b0, 1'b1);
    for (int k = 0; k < DEP; k++) cycle(8'h01, make_row(k, k + 50), 1'b0, 1'b0);
    chk("col0_full", RW'({o_full, o_ready, o_valid}), RW'(3'b100));
    cycle(8'h01, make_row(200, 201), 1'b0, 1'b0);
    chk("col0_overflow", RW'(overflow), RW'(1));
    // Fill the other columns and drain: column 0 must still start at entry 0
    for (int k = 0; k < DEP; k++) cycle(8'hFE, make_row(k + 100, k + 120), 1'b0, 1'b0);
    for (int k = 0; k < DEP; k++) cycle('0, '0, 1'b1, 1'b0);

    // All full; pop together with a full-row write
    cycle('0, '0, 1'b0, 1'b1);
    for (int k = 0; k < DEP; k++) cycle(8'hFF, make_row(k + 3, k + 7), 1'b0, 1'b0);
    d = {RW/32{$urandom}};
    cycle(8'hFF, d, 1'b1, 1'b0);
    chk("full_popwrite", RW'({o_full, overflow}), RW'(2'b10));
    for (int k = 0; k < DEP; k++) cycle('0, '0, 1'b1, 1'b0);

    // rd on empty FIFOs after reset
    cycle('0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle('0, '0, 1'b1, 1'b0);
    chk("empty_rd_out", out, '0);

    // Wrap: 40 rows per column, random skew and random pops
    for (int i = 0; i < COLS; i++) wr_cnt[i] = 0;
    m_pops = 0;
    budget = 0;
    while (m_pops < 40 && budget < 2000) begin
      v = '0;
      d = '0;
      for (int i = 0; i < COLS; i++) begin
        d[i*2*PW +: 2*PW] = {9'(wr_cnt[i]), 9'(wr_cnt[i])};
        if (wr_cnt[i] < 40 && mq[i].size() < DEP && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          wr_cnt[i]++;
        end
      end
      cycle(v, d, 1'($urandom_range(0, 2) != 0), 1'b0);
      budget++;
    end
    chk("wrap_pops", RW'(m_pops), RW'(40));
    // Reset mid-stream
    for (int k = 0; k < 3; k++) cycle(8'hFF, make_row(k + 60, k + 61), 1'b0, 1'b0);
    cycle('0, '0, 1'b1, 1'b0);
    cycle(8'hFF, make_row(9, 9), 1'b1, 1'b1);
    chk("midreset", RW'({out == '0, o_valid, overflow}), RW'(3'b100));

    // Sign handling at pop
    cycle(8'hFF, make_row(9'h1F0, 9'h005), 1'b0, 1'b0);
    cycle('0, '0, 1'b1, 1'b0);
    d = out;
`ifdef PSUM_ROW_COLLECTOR_RELU_EN
    chk("relu_col0", RW'(d[2*PW-1:0]), RW'({9'h005, 9'h000}));
`else
    chk("raw_col0", RW'(d[2*PW-1:0]), RW'({9'h005, 9'h1F0}));
`endif

    // Random traffic, overflow allowed
    for (int k = 0; k < 300; k++) begin
      d = {RW/32{$urandom}};
      d[RW-1 -: 16] = 16'($urandom);
      cycle(COLS'($urandom), d, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) == 0));
    end
    cycle('0, '0, 1'b0, 1'b0);
    chk("scoreboard_empty", RW'(exp_q.size()), RW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
